rdyacpt_rr_arb: RTL and testbench

Round-robin arbiter that merges NUM_PORTS independent ready/accept streams onto one downstream ready/accept channel through a single registered output stage. It is the scheduler in front of the interleaver's ready/accept pipeline stages. It shares that downstream stage fairly between requesters, at up to one beat per clock. Each output beat carries the index of the port it came from.

---
 rtl/rdyacpt_rr_arb.sv | 123 ++++++++++++
 tb/tb_rdyacpt_rr_arb.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rdyacpt_rr_arb.sv
// Round-robin arbiter: NUM_PORTS ready/accept streams into one registered output beat tagged with its source port.
// Optional RDYACPT_ARB_BURST_EN lets the last-served port keep the grant for up to BURST_LEN consecutive beats.
module rdyacpt_rr_arb #(
    parameter int WIDTH     = 8,
    parameter int NUM_PORTS = 4,
    parameter int BURST_LEN = 4,
    localparam int SRC_W    = $clog2(NUM_PORTS)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_PORTS-1:0]       upstream_rdy,
    input  logic [NUM_PORTS*WIDTH-1:0] upstream_data,
    output logic [NUM_PORTS-1:0]       upstream_acpt,
    output logic                       downstream_rdy,
    output logic [WIDTH-1:0]           downstream_data,
    output logic [SRC_W-1:0]           downstream_src,
    input  logic                       downstream_acpt
);

    // Handshake: a beat moves on a posedge where rdy and acpt are both high on
    // the same side; acpt may depend on rdy combinationally, never the reverse.

    logic                 v;
    logic [WIDTH-1:0]     data_q;
    logic [SRC_W-1:0]     src_q;
    logic [SRC_W-1:0]     ptr;

    logic                 en;
    logic                 any_req;
    logic                 xfer;
    logic                 hold;
    logic [SRC_W-1:0]     start;
    logic [SRC_W-1:0]     gidx;
    logic [NUM_PORTS-1:0] grant;
    logic [2*NUM_PORTS-1:0] req2;
    int                   pos;
    int                   sum;

`ifdef RDYACPT_ARB_BURST_EN
    logic [7:0] burst_cnt;
    assign hold = (burst_cnt != 8'd0) && (int'(burst_cnt) < BURST_LEN) && upstream_rdy[ptr];
`else
    assign hold = 1'b0;
`endif

    assign en      = ~v | downstream_acpt;
    assign any_req = |upstream_rdy;
    assign xfer    = en & any_req;

    // Rotate the doubled request vector so the search origin sits at bit 0,
    // then the lowest set bit is the first requester in round-robin order.
    always_comb begin
        start = '0;
        req2  = '0;
        pos   = 0;
        sum   = 0;
        gidx  = '0;
        grant = '0;
        if (hold) begin
            start = ptr;
        end else if (int'(ptr) == NUM_PORTS - 1) begin
            start = '0;
        end else begin
            start = ptr + 1'b1;
        end
        req2 = {upstream_rdy, upstream_rdy} >> start;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req2[i]) begin
                pos = i;
            end
        end
        sum = int'(start) + pos;
        if (sum >= NUM_PORTS) begin
            sum = sum - NUM_PORTS;
        end
        gidx = SRC_W'(sum);
        if (any_req) begin
            grant[gidx] = 1'b1;
        end
    end

    assign upstream_acpt = (reset_n && en) ? grant : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v      <= 1'b0;
            data_q <= '0;
            src_q  <= '0;
            ptr    <= SRC_W'(NUM_PORTS - 1);
        end else if (en) begin
            v <= any_req;
            if (any_req) begin
                data_q <= upstream_data[gidx*WIDTH +: WIDTH];
                src_q  <= gidx;
                ptr    <= gidx;
            end
        end
    end

`ifdef RDYACPT_ARB_BURST_EN
    // Counts beats served back-to-back from port ptr; saturates rather than wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            burst_cnt <= 8'd0;
        end else if (xfer) begin
            if (gidx == ptr) begin
                if (burst_cnt != 8'hFF) begin
                    burst_cnt <= burst_cnt + 8'd1;
                end
            end else begin
                burst_cnt <= 8'd1;
            end
        end else if (!upstream_rdy[ptr]) begin
            burst_cnt <= 8'd0;
        end
    end
`endif

    assign downstream_rdy  = v;
    assign downstream_data = data_q;
    assign downstream_src  = src_q;

endmodule

// File: tb/tb_rdyacpt_rr_arb.sv
// Bench for rdyacpt_rr_arb: directed test-plan steps then random traffic, checked
// against a round-robin reference model and an expected-beat queue.
module tb_rdyacpt_rr_arb;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int SRC_W = 2;
`ifdef RDYACPT_ARB_BURST_EN
    localparam int BL = 3;
`else
    localparam int BL = 1;
`endif

    logic             clk;
    logic             reset_n;
    logic [N-1:0]     upstream_rdy;
    logic [N*W-1:0]   upstream_data;
    logic [N-1:0]     upstream_acpt;
    logic             downstream_rdy;
    logic [W-1:0]     downstream_data;
    logic [SRC_W-1:0] downstream_src;
    logic             downstream_acpt;

    rdyacpt_rr_arb #(
        .WIDTH(W),
        .NUM_PORTS(N),
        .BURST_LEN(BL)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .upstream_rdy(upstream_rdy),
        .upstream_data(upstream_data),
        .upstream_acpt(upstream_acpt),
        .downstream_rdy(downstream_rdy),
        .downstream_data(downstream_data),
        .downstream_src(downstream_src),
        .downstream_acpt(downstream_acpt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // scoreboard: beats the output register should be holding, {src, data}
    logic [SRC_W+W-1:0] exp_q[$];
    int m_last;   // last served port
    int m_run;    // consecutive beats served from m_last (0 = no live burst)

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_last = N - 1;
        m_run  = 0;
    endtask

    // First requesting port in circular order after the last-served one;
    // the last-served port itself comes first while its burst is still live.
    function automatic int model_grant(input logic [N-1:0] rdy);
        int first;
        first = (m_last + 1) % N;
        if (m_run > 0 && m_run < BL && rdy[m_last]) first = m_last;
        for (int k = 0; k < N; k++) begin
            if (rdy[(first + k) % N]) return (first + k) % N;
        end
        return -1;
    endfunction

    // driver: one clock of stimulus, called at posedge+1
    task automatic cycle(input logic [N-1:0] rdy, input logic [N*W-1:0] dat, input logic dacpt);
        int g;
        bit en;
        logic [N-1:0] exp_acpt;
        upstream_rdy    = rdy;
        upstream_data   = dat;
        downstream_acpt = dacpt;
        #2;
        g  = model_grant(rdy);
        en = (exp_q.size() == 0) || dacpt;
        exp_acpt = '0;
        if (en && g >= 0) exp_acpt[g] = 1'b1;
        chk("upstream_acpt", 32'(upstream_acpt), 32'(exp_acpt));
        chk("downstream_rdy", 32'(downstream_rdy), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("downstream_data", 32'(downstream_data), 32'(exp_q[0][W-1:0]));
            chk("downstream_src", 32'(downstream_src), 32'(exp_q[0][SRC_W+W-1:W]));
        end
        @(posedge clk);
        if (dacpt && exp_q.size() != 0) void'(exp_q.pop_front());
        if (en && g >= 0) begin
            exp_q.push_back({SRC_W'(g), dat[g*W +: W]});
            if (g == m_last) begin
                if (m_run < 255) m_run++;
            end else begin
                m_run = 1;
            end
            m_last = g;
        end else if (!rdy[m_last]) begin
            m_run = 0;
        end
        #1;
    endtask

    task automatic rand_cycle();
        cycle(N'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 9) < 7));
    endtask

    localparam logic [N*W-1:0] ALL_DATA = 32'h43_32_21_10;

    initial begin
        reset_n         = 1'b0;
        upstream_rdy    = '1;
        upstream_data   = ALL_DATA;
        downstream_acpt = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_downstream_rdy", 32'(downstream_rdy), 32'd0);
        chk("rst_downstream_data", 32'(downstream_data), 32'd0);
        chk("rst_downstream_src", 32'(downstream_src), 32'd0);
        chk("rst_upstream_acpt", 32'(upstream_acpt), 32'd0);
        upstream_rdy = '0;
        reset_n      = 1'b1;

        // idle
        repeat (10) cycle('0, '0, 1'b1);

        // all ports requesting, full throughput; port 0 has first priority
        upstream_rdy = '1;
        #1;
        chk("first_grant", 32'(upstream_acpt), 32'h1);
        repeat (9) cycle('1, ALL_DATA, 1'b1);
        repeat (2) cycle('0, '0, 1'b1);

        // backpressure on a port-2 beat
        cycle(4'b0100, 32'h00_5A_00_00, 1'b1);
        repeat (3) cycle('1, ALL_DATA, 1'b0);
        chk("bp_data", 32'(downstream_data), 32'h5A);
        chk("bp_src", 32'(downstream_src), 32'd2);
`ifndef RDYACPT_ARB_BURST_EN
        upstream_rdy    = '1;
        downstream_acpt = 1'b1;
        #1;
        chk("bp_release_grant", 32'(upstream_acpt), 32'h8);
`endif
        repeat (4) cycle('1, ALL_DATA, 1'b1);

        // sparse requests on ports 1 and 3
        repeat (8) cycle(4'b1010, ALL_DATA, 1'b1);

        // reset while a beat is held
        cycle('1, ALL_DATA, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("midrst_downstream_rdy", 32'(downstream_rdy), 32'd0);
        chk("midrst_upstream_acpt", 32'(upstream_acpt), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle(4'b1100, ALL_DATA, 1'b1);
        chk("midrst_first_src", 32'(downstream_src), 32'd2);
        repeat (4) cycle(4'b1100, ALL_DATA, 1'b1);

        // burst run, then port 1 drops after one beat
        repeat (2) cycle('0, '0, 1'b1);
        repeat (9) cycle('1, ALL_DATA, 1'b1);
        repeat (3) cycle('1, ALL_DATA, 1'b1);
        cycle(4'b1101, ALL_DATA, 1'b1);
        repeat (4) cycle('1, ALL_DATA, 1'b1);

        // random traffic
        repeat (400) rand_cycle();
        repeat (3) cycle('0, '0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
